// File: rtl/shift_add_mult_if.sv
// Handshake bundle for the shift-add multiplier.
// master: controller (start_i, a_i, b_i); slave: multiplier (busy_o, done_o, product_o).
interface shift_add_mult_if #(
   parameter int WIDTH = 8
);
   logic               start_i;
   logic [WIDTH-1:0]   a_i;
   logic [WIDTH-1:0]   b_i;
   logic               busy_o;
   logic               done_o;
   logic [2*WIDTH-1:0] product_o;

   modport master (
      output start_i,
      output a_i,
      output b_i,
      input  busy_o,
      input  done_o,
      input  product_o
   );

   modport slave (
      input  start_i,
      input  a_i,
      input  b_i,
      output busy_o,
      output done_o,
      output product_o
   );
endinterface

// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one partial product per clock.
// Ports: clk, rst_n (async active-low), bus (slave: start_i, a_i, b_i -> busy_o, done_o, product_o).
// Option: SHIFT_ADD_MULT_SIGNED_EN selects two's complement operands and product.
module shift_add_mult #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   shift_add_mult_if.slave bus
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [PW-1:0]    acc;
   logic [CW-1:0]    cnt;
   logic             busy_q;
   logic             done_q;
   logic [PW-1:0]    product_q;

   logic             accept;
   logic             last;
   logic [PW-1:0]    pp;
   logic [PW-1:0]    acc_nxt;
   logic [PW-1:0]    result;
   logic [WIDTH-1:0] a_load;
   logic [WIDTH-1:0] b_load;

   assign accept  = bus.start_i && ((state == IDLE) || (state == DONE));
   assign last    = (cnt == CW'(WIDTH - 1));
   // Partial product formed in the full product width so the shift never loses bits.
   assign pp      = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
   assign acc_nxt = acc + pp;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
   logic sign;
   // Magnitudes are held unsigned; the most negative value maps to 2^(W-1).
   assign a_load = bus.a_i[WIDTH-1] ? -bus.a_i : bus.a_i;
   assign b_load = bus.b_i[WIDTH-1] ? -bus.b_i : bus.b_i;
   assign result = sign ? -acc_nxt : acc_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign <= 1'b0;
      end else if (accept) begin
         sign <= bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1];
      end
   end
`else
   assign a_load = bus.a_i;
   assign b_load = bus.b_i;
   assign result = acc_nxt;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else if (accept) begin
         state  <= BUSY;
         mcand  <= a_load;
         mplier <= b_load;
         acc    <= '0;
         cnt    <= '0;
         busy_q <= 1'b1;
         done_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
            BUSY: begin
               acc    <= acc_nxt;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  product_q <= result;
                  state     <= DONE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               done_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy_o    = busy_q;
   assign bus.done_o    = done_q;
   assign bus.product_o = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult: directed cases plus random operands
// against an arithmetic reference product.
module tb_shift_add_mult;

   localparam int W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   shift_add_mult_if #(.WIDTH(W)) bus ();

   shift_add_mult #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [2*W-1:0] model(logic [W-1:0] a, logic [W-1:0] b);
`ifdef SHIFT_ADD_MULT_SIGNED_EN
      int sa;
      int sb;
      int p;
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
      return p[2*W-1:0];
`else
      int p;
      p = int'(a) * int'(b);
      return p[2*W-1:0];
`endif
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(logic [W-1:0] a, logic [W-1:0] b);
      bus.a_i     = a;
      bus.b_i     = b;
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
   endtask

   // Called just after the accept edge; ends just after the edge that raises done_o.
   task automatic track(string tag, logic [2*W-1:0] exp, int poke);
      for (int i = 0; i < W; i++) begin
         check({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
         check({tag, "_nodone"}, 32'(bus.done_o), 32'd0);
         if (i == poke) begin
            bus.start_i = 1'b1;
            bus.a_i     = W'($urandom);
            bus.b_i     = W'($urandom);
         end
         tick();
         if (i == poke) bus.start_i = 1'b0;
      end
      check({tag, "_done"}, 32'(bus.done_o), 32'd1);
      check({tag, "_busy_lo"}, 32'(bus.busy_o), 32'd0);
      check({tag, "_prod"}, 32'(bus.product_o), 32'(exp));
   endtask

   task automatic idle_check(string tag, logic [2*W-1:0] exp);
      check({tag, "_done_lo"}, 32'(bus.done_o), 32'd0);
      check({tag, "_busy_lo"}, 32'(bus.busy_o), 32'd0);
      check({tag, "_hold"}, 32'(bus.product_o), 32'(exp));
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           pk;

      bus.start_i = 1'b0;
      bus.a_i     = '0;
      bus.b_i     = '0;
      rst_n       = 1'b0;
      repeat (3) tick();
      idle_check("reset", 16'h0000);
      rst_n = 1'b1;
      tick();
      idle_check("post_reset", 16'h0000);

      start_op(8'd13, 8'd11);
      track("u13x11", 16'd143, -1);
      tick();
      idle_check("u13x11_after", 16'd143);

`ifndef SHIFT_ADD_MULT_SIGNED_EN
      start_op(8'hFF, 8'hFF);
      track("max", 16'hFE01, 3);
      tick();
      idle_check("max_after", 16'hFE01);
`else
      start_op(8'hFB, 8'd7);
      track("s_m5x7", 16'hFFDD, -1);
      tick();
      start_op(8'h80, 8'h80);
      track("s_m128sq", 16'h4000, 3);
      tick();
      start_op(8'h7F, 8'hFF);
      track("s_127xm1", 16'hFF81, -1);
      tick();
      idle_check("s_after", 16'hFF81);
`endif

      start_op(8'h00, 8'hA5);
      track("zero", 16'h0000, -1);
      tick();
      idle_check("zero_after", 16'h0000);

      bus.a_i     = 8'd5;
      bus.b_i     = 8'd7;
      bus.start_i = 1'b1;
      tick();
      bus.a_i = 8'd9;
      bus.b_i = 8'd9;
      track("b2b0", 16'd35, -1);
      tick();
      bus.start_i = 1'b0;
      track("b2b1", 16'd81, -1);
      tick();
      idle_check("b2b_after", 16'd81);

      for (int n = 0; n < 24; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         pk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W - 2)) : -1;
         start_op(ra, rb);
         track("rand", model(ra, rb), pk);
         tick();
         idle_check("rand_after", model(ra, rb));
      end

      start_op(8'd200, 8'd3);
      for (int i = 0; i < 3; i++) begin
         check("rst_mid_busy", 32'(bus.busy_o), 32'd1);
         tick();
      end
      rst_n = 1'b0;
      #1;
      idle_check("rst_async", 16'h0000);
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         idle_check("rst_release", 16'h0000);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
